// File: rtl/nibble_serial_alu_ctrl.sv
// Serial add/subtract sequencer: one shared 4-bit ripple-carry adder is applied
// to the operands one nibble per clock, LSB nibble first, with the carry chained between cycles.

module nibble_rca (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] sum,
  output logic       Cout
);
  logic c1, c2, c3;

  assign sum[0] = A[0] ^ B[0] ^ Cin;
  assign c1     = (A[0] & B[0]) | (Cin & (A[0] ^ B[0]));
  assign sum[1] = A[1] ^ B[1] ^ c1;
  assign c2     = (A[1] & B[1]) | (c1 & (A[1] ^ B[1]));
  assign sum[2] = A[2] ^ B[2] ^ c2;
  assign c3     = (A[2] & B[2]) | (c2 & (A[2] ^ B[2]));
  assign sum[3] = A[3] ^ B[3] ^ c3;
  assign Cout   = (A[3] & B[3]) | (c3 & (A[3] ^ B[3]));
endmodule

// Handshake: start is sampled only in IDLE. An accepted start raises busy for
// NIBBLES cycles. After those cycles done pulses for one cycle and result, carry_out and overflow become valid.
module nibble_serial_alu_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       dbg_state
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_eff;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             last;

  assign dbg_state = state;
  assign nib_a     = a_reg[idx*4 +: 4];
  assign nib_b     = b_eff[idx*4 +: 4];
  assign last      = (idx == IW'(NIBBLES - 1));

  nibble_rca u_rca (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry),
    .sum  (nib_sum),
    .Cout (nib_cout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_eff     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
            a_reg  <= a;
            b_eff  <= op_sub ? ~b : b;
            carry  <= op_sub;
            idx    <= '0;
            result <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          result[idx*4 +: 4] <= nib_sum;
          carry              <= nib_cout;
          if (last) begin
            carry_out <= nib_cout;
            overflow  <= (a_reg[WIDTH-1] ~^ b_eff[WIDTH-1]) & (nib_sum[3] ^ a_reg[WIDTH-1]);
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed bench for nibble_serial_alu_ctrl: a 4-nibble instance plus a 1-nibble instance.
// Expected results are hand-computed; monitors pop them whenever done is seen.

module tb_nibble_serial_alu_ctrl;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // 4-nibble instance
  logic         start = 1'b0, op_sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  // 1-nibble instance
  logic       start1 = 1'b0, op_sub1 = 1'b0;
  logic [3:0] a1 = '0, b1 = '0;
  logic       busy1, done1, carry_out1, overflow1;
  logic [3:0] result1;
  logic [1:0] dbg_state1;

  int total = 0;
  int bad   = 0;

  logic [W+1:0] exp_q[$];
  logic [5:0]   exp1_q[$];

  nibble_serial_alu_ctrl #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  nibble_serial_alu_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_sub(op_sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1), .carry_out(carry_out1),
    .overflow(overflow1), .dbg_state(dbg_state1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("result",    32'(result),    32'(e[W+1:2]));
        check("carry_out", 32'(carry_out), 32'(e[1]));
        check("overflow",  32'(overflow),  32'(e[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && done1) begin
      if (exp1_q.size() == 0) begin
        check("n1_unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [5:0] e;
        e = exp1_q.pop_front();
        check("n1_result",    32'(result1),    32'(e[5:2]));
        check("n1_carry_out", 32'(carry_out1), 32'(e[1]));
        check("n1_overflow",  32'(overflow1),  32'(e[0]));
      end
    end
  end

  // driver: issue one op and check the busy/done timeline cycle by cycle
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic sub,
                        input logic [W-1:0] res, input logic c, input logic v);
    @(negedge clk);
    a = ta; b = tb; op_sub = sub; start = 1'b1;
    exp_q.push_back({res, c, v});
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom_range(0, 1));
    for (int n = 1; n <= NIB + 1; n++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", n), 32'(busy), 32'(n <= NIB));
      check($sformatf("done_c%0d", n), 32'(done), 32'(n == NIB + 1));
    end
  endtask

  task automatic run_op1(input logic [3:0] ta, input logic [3:0] tb, input logic sub,
                         input logic [3:0] res, input logic c, input logic v);
    @(negedge clk);
    a1 = ta; b1 = tb; op_sub1 = sub; start1 = 1'b1;
    exp1_q.push_back({res, c, v});
    @(posedge clk);
    #1;
    start1 = 1'b0;
    @(negedge clk);
    check("n1_busy_c1", 32'(busy1), 32'd1);
    check("n1_done_c1", 32'(done1), 32'd0);
    @(negedge clk);
    check("n1_busy_c2", 32'(busy1), 32'd0);
    check("n1_done_c2", 32'(done1), 32'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_carry_out", 32'(carry_out), 32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    rst = 1'b1;

    // basic add, carry wrap, signed overflow
    run_op(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    // subtract: borrow, and signed overflow with no borrow
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // start during RUN and during DONE must be ignored
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; op_sub = 1'b0; start = 1'b1;
    exp_q.push_back({16'h3333, 1'b0, 1'b0});
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; op_sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ignored_start_done_cycle", 32'(n), 32'd3);
    a = 16'h4444; b = 16'h4444; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ignored_start_idle", 32'(busy), 32'd0);
    end
    check("result_held", 32'(result), 32'h3333);

    // carry_out/overflow nonzero before the reset test
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // asynchronous reset mid-operation; no expectation pushed
    @(negedge clk);
    a = 16'hAAAA; b = 16'h1111; op_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_done",      32'(done),      32'd0);
    check("arst_result",    32'(result),    32'd0);
    check("arst_carry_out", 32'(carry_out), 32'd0);
    check("arst_overflow",  32'(overflow),  32'd0);
    repeat (3) @(negedge clk);
    check("arst_hold_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    run_op(16'hAAAA, 16'h1111, 1'b0, 16'hBBBB, 1'b0, 1'b0);

    // single-nibble build
    run_op1(4'h9, 4'h8, 1'b0, 4'h1, 1'b1, 1'b1);
    run_op1(4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0);

    n = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("queues_drained", 32'(exp_q.size() + exp1_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
